// File: rtl/layer_compositor.sv
// Purpose: merges two scaled line-buffer layers with a horizontal window and border, and drives the palette index.
// Latency: pal_idx is valid 2 cycles after the disp_active cycle that issued the read index.
// Backpressure: none; the pipeline advances every clock and the consumer must accept each pixel.
module layer_compositor #(
  parameter int IDX_W  = 10,
  parameter int FRAC_W = 7,
  parameter int DISP_W = 640
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_of_line,
  input  logic             disp_active,
  output logic [IDX_W-1:0] linebuf_rdidx,
  input  logic [7:0]       layer1_rddata,
  input  logic [7:0]       layer2_rddata,
  output logic [7:0]       pal_idx,
  input  logic [2:0]       regs_addr,
  input  logic [7:0]       regs_wrdata,
  input  logic             regs_write,
  output logic [7:0]       regs_rddata
);

  localparam int ACC_W = IDX_W + FRAC_W;
  localparam logic [9:0] HSTOP_RST = 10'(DISP_W);

  // Programmed register values (what the bus reads back)
  logic [7:0]       ctrl_q;
  logic [7:0]       hscale_q;
  logic [7:0]       border_q;
  logic [9:0]       hstart_q;
  logic [9:0]       hstop_q;
  // Shadow copies used by the active line
  logic [7:0]       hscale_sh;
  logic [9:0]       hstart_sh;
  logic [9:0]       hstop_sh;
  // Next values of the shadowed registers, so a write coinciding with start_of_line lands in the shadow
  logic [7:0]       hscale_n;
  logic [9:0]       hstart_n;
  logic [9:0]       hstop_n;

  logic [ACC_W-1:0] acc;
  logic [9:0]       x;
  logic             in_win;
  logic             active_d;
  logic             in_win_d;
  logic [7:0]       merged;

  // Decode bus writes into next values of the shadowed registers
  always_comb begin
    hscale_n = hscale_q;
    hstart_n = hstart_q;
    hstop_n  = hstop_q;
    if (regs_write) begin
      case (regs_addr)
        3'd1: hscale_n = regs_wrdata;
        3'd3: hstart_n[7:0] = regs_wrdata;
        3'd4: hstop_n[7:0] = regs_wrdata;
        3'd5: begin
          hstop_n[9:8]  = regs_wrdata[3:2];
          hstart_n[9:8] = regs_wrdata[1:0];
        end
        default: ;
      endcase
    end
  end

  // Register file and shadow load on start_of_line
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= 8'h03;
      hscale_q  <= 8'h80;
      border_q  <= 8'h00;
      hstart_q  <= 10'd0;
      hstop_q   <= HSTOP_RST;
      hscale_sh <= 8'h80;
      hstart_sh <= 10'd0;
      hstop_sh  <= HSTOP_RST;
    end else begin
      if (regs_write && regs_addr == 3'd0) ctrl_q <= regs_wrdata;
      if (regs_write && regs_addr == 3'd2) border_q <= regs_wrdata;
      hscale_q <= hscale_n;
      hstart_q <= hstart_n;
      hstop_q  <= hstop_n;
      if (start_of_line) begin
        hscale_sh <= hscale_n;
        hstart_sh <= hstart_n;
        hstop_sh  <= hstop_n;
      end
    end
  end

  // Horizontal step accumulator and pixel counter, both restart on every blanking cycle
  always_ff @(posedge clk) begin
    if (rst || !disp_active) begin
      acc <= '0;
      x   <= 10'd0;
    end else begin
      acc <= acc + ACC_W'(hscale_sh);
      x   <= x + 10'd1;
    end
  end

  assign linebuf_rdidx = acc[ACC_W-1:FRAC_W];
  assign in_win        = (x >= hstart_sh) && (x < hstop_sh);

  // Stage 0: carry pixel qualifiers alongside the line-buffer read
  always_ff @(posedge clk) begin
    if (rst) begin
      active_d <= 1'b0;
      in_win_d <= 1'b0;
    end else begin
      active_d <= disp_active;
      in_win_d <= in_win;
    end
  end

  // Layer merge: opaque top wins, otherwise enabled bottom shows through even when transparent
  always_comb begin
    logic [7:0] top_px;
    logic [7:0] bot_px;
    logic       top_en;
    logic       bot_en;
    top_px = ctrl_q[2] ? layer1_rddata : layer2_rddata;
    bot_px = ctrl_q[2] ? layer2_rddata : layer1_rddata;
    top_en = ctrl_q[2] ? ctrl_q[0] : ctrl_q[1];
    bot_en = ctrl_q[2] ? ctrl_q[1] : ctrl_q[0];
    merged = 8'h00;
    if (top_en && top_px != 8'h00) merged = top_px;
    else if (bot_en)               merged = bot_px;
  end

  // Stage 1: select blank, border or merged pixel into the palette address register
  always_ff @(posedge clk) begin
    if (rst)            pal_idx <= 8'h00;
    else if (!active_d) pal_idx <= 8'h00;
    else if (!in_win_d) pal_idx <= border_q;
    else                pal_idx <= merged;
  end

  // Register readback returns programmed values, not shadows
  always_comb begin
    regs_rddata = 8'h00;
    case (regs_addr)
      3'd0: regs_rddata = ctrl_q;
      3'd1: regs_rddata = hscale_q;
      3'd2: regs_rddata = border_q;
      3'd3: regs_rddata = hstart_q[7:0];
      3'd4: regs_rddata = hstop_q[7:0];
      3'd5: regs_rddata = {4'b0000, hstop_q[9:8], hstart_q[9:8]};
      default: regs_rddata = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_layer_compositor.sv
module tb_layer_compositor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_of_line;
  logic       disp_active;
  logic [9:0] linebuf_rdidx;
  logic [7:0] layer1_rddata;
  logic [7:0] layer2_rddata;
  logic [7:0] pal_idx;
  logic [2:0] regs_addr;
  logic [7:0] regs_wrdata;
  logic       regs_write;
  logic [7:0] regs_rddata;

  layer_compositor #(.IDX_W(10), .FRAC_W(7), .DISP_W(640)) dut (
    .clk(clk), .rst(rst), .start_of_line(start_of_line), .disp_active(disp_active),
    .linebuf_rdidx(linebuf_rdidx), .layer1_rddata(layer1_rddata), .layer2_rddata(layer2_rddata),
    .pal_idx(pal_idx), .regs_addr(regs_addr), .regs_wrdata(regs_wrdata),
    .regs_write(regs_write), .regs_rddata(regs_rddata)
  );

  always #5 clk = ~clk;

  // Line buffers with one-cycle read latency
  logic [7:0] mem1 [1024];
  logic [7:0] mem2 [1024];
  always @(posedge clk) begin
    layer1_rddata <= mem1[linebuf_rdidx];
    layer2_rddata <= mem2[linebuf_rdidx];
  end

  typedef struct {
    bit         chk;
    logic [7:0] v;
    int         phase;
    int         pix;
  } exp_t;
  exp_t q[$];

  typedef struct { logic [2:0] a; logic [7:0] v; } rd_vec_t;
  typedef struct { logic [7:0] ctrl; logic [7:0] te; logic [7:0] to; } mrg_vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int phase   = 0;

  // Bench-side view of programmed registers and active shadows
  logic [7:0] m_ctrl, m_scale, m_border, sh_scale;
  logic [9:0] m_hs, m_he, sh_hs, sh_he;

  task automatic model_reset();
    m_ctrl = 8'h03; m_scale = 8'h80; m_border = 8'h00; m_hs = 10'd0; m_he = 10'd640;
    sh_scale = 8'h80; sh_hs = 10'd0; sh_he = 10'd640;
  endtask

  task automatic chk_val(input string nm, input int got, input int expv);
    n_tests++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s phase %0d: got %0h, expected %0h", nm, phase, got, expv);
    end
  endtask

  // Advance one clock; compare the pixel whose expectation was queued two cycles ago
  task automatic adv();
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() >= 2) begin
      e = q.pop_front();
      if (e.chk) begin
        n_tests++;
        if (pal_idx !== e.v) begin
          n_fail++;
          $display("FAIL pal_idx phase %0d pixel %0d: got %02h, expected %02h", e.phase, e.pix, pal_idx, e.v);
        end
      end
    end
  endtask

  task automatic drive(input bit r, input bit da, input bit sol, input bit wr,
                       input logic [2:0] a, input logic [7:0] d,
                       input bit chk, input logic [7:0] v, input int pix);
    exp_t e;
    exp_t e0;
    rst = r; disp_active = da; start_of_line = sol;
    regs_write = wr; regs_addr = a; regs_wrdata = d;
    // Reset blanks the pixel already in flight as well
    if (r && q.size() > 0) begin
      e0 = q.pop_front(); e0.chk = 1'b1; e0.v = 8'h00; q.push_front(e0);
    end
    e.chk = r ? 1'b1 : chk; e.v = r ? 8'h00 : v; e.phase = phase; e.pix = pix;
    q.push_back(e);
  endtask

  task automatic cyc(input bit r, input bit da, input bit sol, input bit wr,
                     input logic [2:0] a, input logic [7:0] d, input bit chk,
                     input logic [7:0] v, input int pix);
    adv();
    drive(r, da, sol, wr, a, d, chk, v, pix);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, '0, '0, '0, 3'd0, 8'h00, '1, 8'h00, -1);
  endtask

  task automatic wreg(input logic [2:0] a, input logic [7:0] d, input bit sol);
    cyc('0, '0, sol, '1, a, d, '1, 8'h00, -1);
    case (a)
      3'd0: m_ctrl = d;
      3'd1: m_scale = d;
      3'd2: m_border = d;
      3'd3: m_hs[7:0] = d;
      3'd4: m_he[7:0] = d;
      3'd5: begin m_he[9:8] = d[3:2]; m_hs[9:8] = d[1:0]; end
      default: ;
    endcase
    if (sol) begin sh_scale = m_scale; sh_hs = m_hs; sh_he = m_he; end
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [7:0] v);
    regs_addr = a;
    #1;
    chk_val($sformatf("regs[%0d]", a), int'(regs_rddata), int'(v));
  endtask

  function automatic logic [7:0] merge_px(input logic [7:0] p1, input logic [7:0] p2);
    logic [7:0] top, bot;
    bit ten, ben;
    top = m_ctrl[2] ? p1 : p2;
    bot = m_ctrl[2] ? p2 : p1;
    ten = m_ctrl[2] ? m_ctrl[0] : m_ctrl[1];
    ben = m_ctrl[2] ? m_ctrl[1] : m_ctrl[0];
    if (ten && top != 8'h00) return top;
    if (ben) return bot;
    return 8'h00;
  endfunction

  // One blanking cycle (optionally start_of_line), n active pixels, then trail blanking cycles
  task automatic run_line(input int n, input bit sol, input int trail,
                          input bit use_tab, input logic [7:0] te, input logic [7:0] to);
    int idx;
    logic [7:0] v;
    cyc('0, '0, sol, '0, 3'd0, 8'h00, '1, 8'h00, -1);
    if (sol) begin sh_scale = m_scale; sh_hs = m_hs; sh_he = m_he; end
    for (int k = 0; k < n; k++) begin
      adv();
      idx = ((k * int'(sh_scale)) % 131072) >> 7;
      chk_val($sformatf("rdidx pixel %0d", k), int'(linebuf_rdidx), idx);
      if (!(k >= int'(sh_hs) && k < int'(sh_he))) v = m_border;
      else if (use_tab)                          v = (k % 2 == 0) ? te : to;
      else                                       v = merge_px(mem1[idx], mem2[idx]);
      drive('0, '1, '0, '0, 3'd0, 8'h00, '1, v, k);
    end
    idle(trail);
  endtask

  rd_vec_t  rd_tab [8];
  mrg_vec_t mrg_tab[6];

  initial begin
    rd_tab = '{'{3'd0, 8'h03}, '{3'd1, 8'h80}, '{3'd2, 8'h00}, '{3'd3, 8'h00},
               '{3'd4, 8'h80}, '{3'd5, 8'h08}, '{3'd6, 8'h00}, '{3'd7, 8'h00}};
    mrg_tab = '{'{8'h03, 8'h55, 8'h11}, '{8'h07, 8'h11, 8'h11}, '{8'h02, 8'h55, 8'h00},
                '{8'h01, 8'h11, 8'h11}, '{8'h04, 8'h00, 8'h00}, '{8'h06, 8'h55, 8'h00}};
    for (int i = 0; i < 1024; i++) begin mem1[i] = 8'(i); mem2[i] = 8'h00; end
    rst = 1'b1; start_of_line = 1'b0; disp_active = 1'b0;
    regs_addr = 3'd0; regs_wrdata = 8'h00; regs_write = 1'b0;
    model_reset();

    // Reset and register defaults
    phase = 0;
    cyc('1, '0, '0, '0, 3'd0, 8'h00, '1, 8'h00, -1);
    cyc('1, '0, '0, '0, 3'd0, 8'h00, '1, 8'h00, -1);
    idle(2);
    for (int i = 0; i < 8; i++) rd_chk(rd_tab[i].a, rd_tab[i].v);

    // Full 1:1 line, identity layer 1
    phase = 1;
    run_line(640, '1, 3, '0, 8'h00, 8'h00);

    // HSCALE only takes effect at start_of_line
    phase = 2;
    wreg(3'd1, 8'h40, '0);
    run_line(20, '0, 3, '0, 8'h00, 8'h00);
    run_line(20, '1, 3, '0, 8'h00, 8'h00);
    wreg(3'd1, 8'h80, '1);
    run_line(10, '0, 3, '0, 8'h00, 8'h00);
    wreg(3'd1, 8'h00, '1);
    run_line(10, '0, 3, '0, 8'h00, 8'h00);
    wreg(3'd1, 8'h80, '1);

    // Layer merge rules
    phase = 3;
    for (int i = 0; i < 1024; i++) begin mem1[i] = 8'h11; mem2[i] = (i % 2 == 0) ? 8'h55 : 8'h00; end
    for (int t = 0; t < 6; t++) begin
      wreg(3'd0, mrg_tab[t].ctrl, '0);
      run_line(16, '0, 3, '1, mrg_tab[t].te, mrg_tab[t].to);
    end

    // Horizontal window and border
    phase = 4;
    for (int i = 0; i < 1024; i++) begin mem1[i] = 8'(i); mem2[i] = 8'h00; end
    wreg(3'd0, 8'h03, '0);
    wreg(3'd2, 8'hAA, '0);
    wreg(3'd3, 8'd16, '0);
    wreg(3'd4, 8'd32, '0);
    wreg(3'd5, 8'h00, '0);
    run_line(640, '1, 3, '0, 8'h00, 8'h00);
    wreg(3'd3, 8'd40, '0);
    wreg(3'd4, 8'd20, '0);
    run_line(64, '1, 3, '0, 8'h00, 8'h00);
    rd_chk(3'd3, 8'd40);
    rd_chk(3'd5, 8'h00);

    // Mid-line reset
    phase = 5;
    wreg(3'd3, 8'd0, '0);
    wreg(3'd4, 8'h80, '0);
    wreg(3'd5, 8'h08, '1);
    wreg(3'd0, 8'h07, '0);
    wreg(3'd1, 8'h40, '0);
    run_line(12, '0, 0, '0, 8'h00, 8'h00);
    cyc('1, '1, '0, '0, 3'd0, 8'h00, '1, 8'h00, -1);
    model_reset();
    idle(1);
    for (int i = 0; i < 8; i++) rd_chk(rd_tab[i].a, rd_tab[i].v);
    run_line(20, '0, 3, '0, 8'h00, 8'h00);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
